rle_decoder: RTL and testbench

Run-length decoder that expands (value, count) pairs from the RLE compression path back into a flat stream of 13-bit signed EEG/DCT samples. It sits on the decompression side of the DCT+RLE system, between the stored pair stream and the inverse-DCT stage. Both sides use valid/ready handshakes, so a stalled downstream stage stalls expansion without losing samples.

---
 rtl/rle_decoder.sv | 130 +++++++++++++
 tb/tb_rle_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decoder.sv
// rtl/rle_decoder.sv - run-length decoder expanding (value, count) pairs into a sample stream; optional prefetch via RLD_PREFETCH_EN
module rle_decoder #(
  parameter int DW = 13,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] in_value,
  input  logic [CW-1:0]        in_count,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic signed [DW-1:0] out_sample,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t               state, state_n;
  logic signed [DW-1:0] value, value_n;
  logic [CW:0]          remaining, remaining_n;
  logic                 accept, xfer, last_xfer;

  // A count of zero stands for the longest run, 2^CW beats.
  function automatic logic [CW:0] run_len(input logic [CW-1:0] c);
    if (c == '0) run_len = {1'b1, {CW{1'b0}}};
    else         run_len = {1'b0, c};
  endfunction

  assign out_valid  = (state == EXPAND);
  assign out_sample = value;
  assign out_last   = out_valid && (remaining == {{CW{1'b0}}, 1'b1});
  assign accept     = in_valid && in_ready;
  assign xfer       = out_valid && out_ready;
  assign last_xfer  = xfer && out_last;

`ifdef RLD_PREFETCH_EN
  logic signed [DW-1:0] hold_value, hold_value_n;
  logic [CW-1:0]        hold_count, hold_count_n;
  logic                 hold_valid, hold_valid_n;

  // Input side only stalls when the single holding slot is occupied.
  assign in_ready = !hold_valid;
`else
  logic hold_valid;

  assign hold_valid = 1'b0;
  assign in_ready   = (state == IDLE);
`endif

  assign busy = (state == EXPAND) || hold_valid;

  // Next-state logic: load a run, count beats down, chain into the next run.
  always_comb begin
    state_n     = state;
    value_n     = value;
    remaining_n = remaining;
`ifdef RLD_PREFETCH_EN
    hold_value_n = hold_value;
    hold_count_n = hold_count;
    hold_valid_n = hold_valid;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          value_n     = in_value;
          remaining_n = run_len(in_count);
          state_n     = EXPAND;
        end
      end
      EXPAND: begin
        if (xfer) begin
          remaining_n = remaining - {{CW{1'b0}}, 1'b1};
          if (out_last) begin
`ifdef RLD_PREFETCH_EN
            if (hold_valid) begin
              value_n      = hold_value;
              remaining_n  = run_len(hold_count);
              hold_valid_n = 1'b0;
            end else if (accept) begin
              value_n     = in_value;
              remaining_n = run_len(in_count);
            end else begin
              state_n = IDLE;
            end
`else
            state_n = IDLE;
`endif
          end
        end
`ifdef RLD_PREFETCH_EN
        // A pair arriving mid-run waits in the holding slot; one arriving on
        // the last beat with the slot empty went straight to the active run.
        if (accept && !last_xfer) begin
          hold_value_n = in_value;
          hold_count_n = in_count;
          hold_valid_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      value     <= '0;
      remaining <= '0;
`ifdef RLD_PREFETCH_EN
      hold_value <= '0;
      hold_count <= '0;
      hold_valid <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      value     <= value_n;
      remaining <= remaining_n;
`ifdef RLD_PREFETCH_EN
      hold_value <= hold_value_n;
      hold_count <= hold_count_n;
      hold_valid <= hold_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_rle_decoder.sv
// tb/tb_rle_decoder.sv - scoreboard testbench for rle_decoder
module tb_rle_decoder;
  localparam int DW = 13;
  localparam int CW = 8;
`ifdef RLD_PREFETCH_EN
  localparam int BUBBLES = 0;
`else
  localparam int BUBBLES = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic signed [DW-1:0] in_value = '0;
  logic [CW-1:0]        in_count = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] out_sample;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 out_last;
  logic                 busy;

  rle_decoder #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_value(in_value), .in_count(in_count), .in_valid(in_valid), .in_ready(in_ready),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] s;
    logic          l;
  } exp_t;

  exp_t          q[$];
  int            xfer_cyc[$];
  int            checks = 0;
  int            failures = 0;
  int            n_xfer = 0;
  int            cyc = 0;
  bit            rnd_ready = 1'b0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] sv_sample;
  logic          sv_valid, sv_last;
  exp_t          e;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: a pair expands to n copies of its value, last flag on copy n.
  task automatic push_expect(input logic [DW-1:0] v, input int c);
    int n;
    exp_t x;
    n = (c == 0) ? (1 << CW) : c;
    for (int i = 0; i < n; i++) begin
      x.s = v;
      x.l = (i == n - 1);
      q.push_back(x);
    end
  endtask

  task automatic send(input logic [DW-1:0] v, input int c);
    bit done;
    int budget;
    done = 1'b0;
    budget = 0;
    in_value = v;
    in_count = CW'(c);
    in_valid = 1'b1;
    while (!done && budget < 3000) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        push_expect(v, c);
        done = 1'b1;
      end
      budget++;
    end
    if (!done) chk("accept_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
    in_value = DW'($urandom);
    in_count = CW'($urandom);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((q.size() != 0 || busy) && budget < 20000) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_sample"}, int'(out_sample), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_last"}, int'(out_last), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  task automatic chk_span(input string name, input int base, input int beats, input int bub);
    if (xfer_cyc.size() < base + beats) begin
      chk({name, "_beats"}, xfer_cyc.size() - base, beats);
    end else begin
      chk(name, xfer_cyc[base + beats - 1] - xfer_cyc[base] + 1, beats + bub);
    end
  endtask

  // Random downstream backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: pop and compare on every transfer; check stability while stalled.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (stall_prev) begin
        chk("stall_sample", int'({1'b0, out_sample}), int'({1'b0, sv_sample}));
        chk("stall_valid", int'(out_valid), int'(sv_valid));
        chk("stall_last", int'(out_last), int'(sv_last));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("sample", int'({1'b0, out_sample}), int'({1'b0, e.s}));
          chk("last", int'(out_last), int'(e.l));
        end
        n_xfer++;
        xfer_cyc.push_back(cyc);
      end
`ifndef RLD_PREFETCH_EN
      if (out_valid) chk("in_ready_during_run", int'(in_ready), 0);
`endif
      stall_prev = out_valid && !out_ready;
      sv_sample  = out_sample;
      sv_valid   = out_valid;
      sv_last    = out_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    int base;
    int pat[7];
    int c;
    pat = '{1, 0, 0, 1, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset in the middle of a run discards it.
    base = n_xfer;
    send(13'h1FF9, 10);
    while (n_xfer < base + 3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_reset");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = n_xfer;
    send(13'd5, 2);
    drain();
    chk("post_reset_beats", n_xfer - base, 2);

    // Basic expansion with the bubble count between runs.
    base = xfer_cyc.size();
    send(13'd100, 3);
    send(13'h1000, 1);
    send(13'd4095, 2);
    drain();
    chk_span("basic_span", base, 6, BUBBLES);

    // Count 0 means 256 beats.
    base = n_xfer;
    send(13'h1FFF, 0);
    drain();
    chk("count0_beats", n_xfer - base, 256);

    // Backpressure pattern.
    out_ready = 1'b0;
    base = n_xfer;
    send(13'd42, 4);
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i][0];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
    chk("backpressure_beats", n_xfer - base, 4);

`ifdef RLD_PREFETCH_EN
    // Back-to-back pairs chain without bubbles.
    base = xfer_cyc.size();
    send(13'd1, 2);
    send(13'd2, 2);
    send(13'd3, 1);
    drain();
    chk_span("b2b_span", base, 5, 0);
`endif

    // Sign and width extremes.
    base = n_xfer;
    send(13'h1000, 1);
    send(13'h0FFF, 1);
    send(13'd0, 255);
    drain();
    chk("sign_width_beats", n_xfer - base, 257);

    // Randomized pairs under random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 19) == 0) c = 0;
      else c = $urandom_range(1, 12);
      send(DW'($urandom), c);
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("final_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
